// File: rtl/hpi_target_model_if.sv
// hpi_target_model_if: HPI host-port control pins (select, strobes, soft reset, interrupt)
interface hpi_target_model_if;
  logic [1:0] OTG_ADDR;
  logic       OTG_RD_N;
  logic       OTG_WR_N;
  logic       OTG_CS_N;
  logic       OTG_RST_N;
  logic       OTG_INT;
  modport master (output OTG_ADDR, OTG_RD_N, OTG_WR_N, OTG_CS_N, OTG_RST_N, input OTG_INT);
  modport slave  (input OTG_ADDR, OTG_RD_N, OTG_WR_N, OTG_CS_N, OTG_RST_N, output OTG_INT);
endinterface

// File: rtl/hpi_target_model.sv
// hpi_target_model: CY7C67200-style HPI target with DATA/MAILBOX/ADDRESS/STATUS registers.
// Optional HPI_TARGET_IRQ_EN: drive OTG_INT from the local-to-host mailbox full flag.
module hpi_target_model #(
  parameter int MEM_AW = 10
) (
  input  logic              Clk,
  input  logic              Reset_N,
  hpi_target_model_if.slave hpi,
  inout  wire  [15:0]       OTG_DATA,
  output logic [15:0]       mbx_in_data,
  output logic              mbx_in_valid,
  input  logic              mbx_in_ack,
  input  logic [15:0]       mbx_out_data,
  input  logic              mbx_out_wr
);
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MBX  = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  logic [15:0]       r_data_q;
  logic [1:0]        r_addr_q, r_addr_qq;
  logic              r_rd_q, r_rd_qq, r_wr_q, r_wr_qq, r_cs_q, r_cs_qq, r_rst_q;
  logic [15:0]       r_ptr, r_lat, r_obox, r_in_data;
  logic              r_in_valid, r_out_full;
  logic [15:0]       r_mem [2**MEM_AW];
  logic              w_wr_ev, w_rd_st, w_rd_end, w_oe, w_mem_we;
  logic [MEM_AW-1:0] w_idx;
  logic [15:0]       w_rd_val;

  // Two-stage registration of host pins; strobes idle high so reset never fakes an edge
  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) begin
      r_data_q  <= '0;
      r_addr_q  <= '0;
      r_addr_qq <= '0;
      r_rd_q    <= 1'b1;
      r_rd_qq   <= 1'b1;
      r_wr_q    <= 1'b1;
      r_wr_qq   <= 1'b1;
      r_cs_q    <= 1'b1;
      r_cs_qq   <= 1'b1;
      r_rst_q   <= 1'b1;
    end else begin
      r_data_q  <= OTG_DATA;
      r_addr_q  <= hpi.OTG_ADDR;
      r_addr_qq <= r_addr_q;
      r_rd_q    <= hpi.OTG_RD_N;
      r_rd_qq   <= r_rd_q;
      r_wr_q    <= hpi.OTG_WR_N;
      r_wr_qq   <= r_wr_q;
      r_cs_q    <= hpi.OTG_CS_N;
      r_cs_qq   <= r_cs_q;
      r_rst_q   <= hpi.OTG_RST_N;
    end

  // Access event decode; a strobe with WR also low is a write, so reads require WR high
  always_comb begin
    w_wr_ev  = !r_cs_q && !r_wr_q && r_wr_qq;
    w_rd_st  = !r_cs_q && !r_rd_q && r_rd_qq && r_wr_q;
    w_rd_end = r_rd_q && !r_rd_qq && !r_cs_qq && r_wr_qq;
    w_oe     = !r_cs_q && !r_rd_q && r_wr_q;
    w_idx    = r_ptr[MEM_AW:1];
    w_mem_we = w_wr_ev && r_addr_q == REG_DATA && r_rst_q;
    w_rd_val = r_addr_q == REG_DATA ? r_mem[w_idx] :
               r_addr_q == REG_MBX  ? r_obox :
               r_addr_q == REG_ADDR ? r_ptr : {14'b0, r_out_full, r_in_valid};
  end

  // Register file, pointer and mailbox flags; host soft reset clears all but memory
  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) begin
      r_ptr      <= '0;
      r_lat      <= '0;
      r_obox     <= '0;
      r_out_full <= 1'b0;
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
    end else if (!r_rst_q) begin
      r_ptr      <= '0;
      r_lat      <= '0;
      r_obox     <= '0;
      r_out_full <= 1'b0;
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
    end else begin
      if (w_wr_ev && r_addr_q == REG_ADDR)
        r_ptr <= r_data_q;
      else if (w_mem_we || (w_rd_end && r_addr_qq == REG_DATA))
        r_ptr <= r_ptr + 16'd2;
      if (w_rd_st)
        r_lat <= w_rd_val;
      if (w_wr_ev && r_addr_q == REG_MBX) begin
        r_in_data  <= r_data_q;
        r_in_valid <= 1'b1;
      end else if (mbx_in_ack)
        r_in_valid <= 1'b0;
      if (mbx_out_wr) begin
        r_obox     <= mbx_out_data;
        r_out_full <= 1'b1;
      end else if (w_rd_end && r_addr_qq == REG_MBX)
        r_out_full <= 1'b0;
    end

  // Backing word memory, intentionally not reset
  always_ff @(posedge Clk)
    if (w_mem_we)
      r_mem[w_idx] <= r_data_q;

  assign OTG_DATA     = w_oe ? r_lat : 16'hzzzz;
  assign mbx_in_data  = r_in_data;
  assign mbx_in_valid = r_in_valid;
`ifdef HPI_TARGET_IRQ_EN
  assign hpi.OTG_INT  = r_out_full;
`else
  assign hpi.OTG_INT  = 1'b0;
`endif
endmodule
